// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes them to imem from address 0; holds the core in reset until done.
// Latency: imem_we one cycle after the 4th accepted byte (one word per 5 cycles). byte_ready is low outside COLLECT/CHECK.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state).
module imem_loader #(
  parameter int MEM_WORDS = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 cpu_rst_n
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, CHECK} state_t;
  localparam state_t END_STATE = CHECK;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  localparam state_t END_STATE = DONE;
`endif

  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(MEM_WORDS);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, num_q;
  logic [1:0]             idx_q;
  logic [23:0]            asm_q;
  logic [31:0]            addr_q, wdata_q;
  logic                   error_q;
  logic [7:0]             csum_q;
  logic                   start_ok, too_long, xfer, last_word;

  assign start_ok  = start && (state_q == IDLE || state_q == DONE);
  assign too_long  = num_words > MAX_WORDS;
  assign xfer      = byte_valid && byte_ready;
  assign last_word = (cnt_q == num_q - CNT_WIDTH'(1));

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign error      = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          done      = 1'b1;
          cpu_rst_n = 1'b1;
        end
        // DONE re-arms exactly like IDLE; a rejected length drops back to IDLE
        if (start) begin
          if (num_words == '0)  state_d = END_STATE;
          else if (too_long)    state_d = IDLE;
          else                  state_d = COLLECT;
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer && idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        state_d = last_word ? END_STATE : COLLECT;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_d = (byte_in == csum_q) ? DONE : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
      csum_q  <= '0;
    end else begin
      if (start_ok) begin
        error_q <= too_long;
        if (!too_long) begin
          num_q  <= num_words;
          cnt_q  <= '0;
          idx_q  <= '0;
          asm_q  <= '0;
          csum_q <= '0;
        end
      end
      if (state_q == COLLECT && xfer) begin
        idx_q  <= idx_q + 2'd1;
        csum_q <= csum_q ^ byte_in;
        // The 4th byte completes the word straight into the write registers
        case (idx_q)
          2'd0:    asm_q[7:0]   <= byte_in;
          2'd1:    asm_q[15:8]  <= byte_in;
          2'd2:    asm_q[23:16] <= byte_in;
          default: begin
            wdata_q <= {byte_in, asm_q};
            addr_q  <= 32'({cnt_q, 2'b00});
          end
        endcase
      end
      if (state_q == WRITE) cnt_q <= cnt_q + CNT_WIDTH'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_q == CHECK && byte_valid && byte_in != csum_q) error_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; writes are logged from imem_we on the falling edge.
module tb_imem_loader;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, imem_we, busy, done, error, cpu_rst_n;
  logic [31:0]   imem_addr, imem_wdata;

  int vectors = 0;
  int fails = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int wr_n = 0;

  imem_loader #(.MEM_WORDS(64), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (byte_ready) ok = 1'b1;
      tick;
    end
    byte_valid = 1'b0;
    check("byte_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start     = 1'b1;
    num_words = n;
    tick;
    start     = 1'b0;
  endtask

  // Last WRITE cycle, then the checksum byte when the feature is built in
  task automatic finish_load(input logic [7:0] csum);
    tick;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`else
    if (csum == 8'hxx) $display("unused checksum");
`endif
  endtask

  function automatic logic [7:0] bytev(input int i);
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    int base;
    logic [7:0] cs;
    logic [31:0] w;

    // Reset values
    tick; tick;
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_imem_we", {31'b0, imem_we}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Two-word image
    base = wr_n;
    do_start(8'd2);
    check("t1_ready", {31'b0, byte_ready}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    finish_load(8'h90);
    check("t1_nwrites", wr_n - base, 32'd2);
    check("t1_addr0", wr_addr[base], 32'd0);
    check("t1_data0", wr_data[base], 32'h00000513);
    check("t1_addr1", wr_addr[base+1], 32'd4);
    check("t1_data1", wr_data[base+1], 32'h00100593);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);
    check("t1_busy_low", {31'b0, busy}, 32'd0);
    check("t1_addr_hold", imem_addr, 32'd4);

    // Zero-length image
    base = wr_n;
    do_start(8'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t0_in_check", {31'b0, byte_ready}, 32'd1);
    send_byte(8'h00);
`endif
    check("t0_done", {31'b0, done}, 32'd1);
    check("t0_nwrites", wr_n - base, 32'd0);

    // Eight words with byte_valid toggling
    base = wr_n;
    cs = 8'h00;
    do_start(8'd8);
    check("t2_rearm_done", {31'b0, done}, 32'd0);
    check("t2_rearm_cpu_rst", {31'b0, cpu_rst_n}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      send_byte(bytev(i));
      cs = cs ^ bytev(i);
      tick;
    end
    finish_load(cs);
    check("t2_nwrites", wr_n - base, 32'd8);
    for (int k = 0; k < 8; k++) begin
      w = {bytev(4*k+3), bytev(4*k+2), bytev(4*k+1), bytev(4*k)};
      check("t2_addr", wr_addr[base+k], 32'(4*k));
      check("t2_data", wr_data[base+k], w);
    end
    check("t2_done", {31'b0, done}, 32'd1);

    // Over-length image rejected, then a valid start clears error
    base = wr_n;
    do_start(8'd65);
    check("t3_error", {31'b0, error}, 32'd1);
    check("t3_ready", {31'b0, byte_ready}, 32'd0);
    check("t3_done", {31'b0, done}, 32'd0);
    check("t3_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    tick; tick; tick;
    check("t3_idle", {31'b0, busy}, 32'd0);
    check("t3_nwrites", wr_n - base, 32'd0);
    do_start(8'd1);
    check("t3_err_clear", {31'b0, error}, 32'd0);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    finish_load(8'h16);
    check("t3_nwrites2", wr_n - base, 32'd1);
    check("t3_data", wr_data[base], 32'h00000513);
    check("t3_done2", {31'b0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum
    do_start(8'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    finish_load(8'h17);
    check("cs_error", {31'b0, error}, 32'd1);
    check("cs_done", {31'b0, done}, 32'd0);
    check("cs_busy", {31'b0, busy}, 32'd0);
    check("cs_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
`endif

    // Second start during COLLECT is ignored
    base = wr_n;
    do_start(8'd2);
    send_byte(8'h11); send_byte(8'h22);
    do_start(8'd1);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    finish_load(8'h88);
    check("t5_nwrites", wr_n - base, 32'd2);
    check("t5_data0", wr_data[base], 32'h44332211);
    check("t5_data1", wr_data[base+1], 32'h88776655);
    check("t5_addr1", wr_addr[base+1], 32'd4);
    check("t5_done", {31'b0, done}, 32'd1);

    // Asynchronous reset mid-load
    base = wr_n;
    do_start(8'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    rst_n = 1'b0;
    #1;
    check("t4_ready", {31'b0, byte_ready}, 32'd0);
    check("t4_we", {31'b0, imem_we}, 32'd0);
    check("t4_addr", imem_addr, 32'd0);
    check("t4_wdata", imem_wdata, 32'd0);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_done", {31'b0, done}, 32'd0);
    check("t4_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
    check("t4_nwrites", wr_n - base, 32'd1);
    check("t4_waddr0", wr_addr[base], 32'd0);
    check("t4_wdata0", wr_data[base], 32'h04030201);
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    check("t4_no_more_writes", wr_n - base, 32'd1);
    check("t4_idle", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to instruction_memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word sequentially into instruction memory starting at byte address 0.
- Holds the core in reset until the programmed image is complete. Sits between the host/boot link and the instruction memory write port.

Parameters:
- MEM_WORDS, 64, instruction memory depth in 32-bit words; upper bound on image length.
- CNT_WIDTH, 8, width of num_words and the internal word counter; must satisfy 2^CNT_WIDTH > MEM_WORDS.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begin a load of num_words words
- num_words  input  CNT_WIDTH  image length in words, sampled on start
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in valid this cycle
- byte_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  32  byte address of write, word-aligned
- imem_wdata  output  32  word to write
- busy  output  1  load in progress
- done  output  1  image complete
- error  output  1  length or checksum fault, sticky until next start
- cpu_rst_n  output  1  active-low core reset, released only when done

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, cpu_rst_n=0. Word counter, byte index and assembly register all cleared.
- States: IDLE, COLLECT, WRITE, DONE, plus CHECK when the optional feature is compiled in.
- IDLE, start=1:
  - num_words=0 -> DONE next cycle.
  - num_words>MEM_WORDS -> error=1, remain IDLE.
  - Otherwise -> COLLECT; clear error, counter and byte index.
- COLLECT: byte_ready=1, busy=1. A byte transfers when byte_valid and byte_ready are both high.
  - Byte k of the word (k=0..3) goes into bits [8k+7:8k].
  - Byte index wraps 3->0.
  - On the 4th transfer -> WRITE.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=counter*4, imem_wdata=assembled word, byte_ready=0.
  - Counter increments.
  - If counter was num_words-1 -> DONE (or CHECK when the feature is on); else -> COLLECT.
- Latency: imem_we asserts the cycle after the 4th accepted byte. Peak throughput is one word per 5 cycles.
- DONE: done=1, busy=0, cpu_rst_n=1, byte_ready=0.
  - Stays in DONE until start.
  - start in DONE re-arms as from IDLE: done drops and cpu_rst_n drops the next cycle.
- start while busy: ignored. num_words is not resampled.
- byte_valid while byte_ready=0: no transfer; the byte must be held by the source.
- imem_we is never high outside WRITE.
- rst_n low mid-load: immediate return to reset values; a partial word is discarded and never written.
- imem_addr holds its last value when imem_we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - After the last WRITE, the loader enters CHECK with byte_ready=1 and accepts one extra byte.
  - That byte must equal the XOR of all image bytes.
  - Match -> DONE.
  - Mismatch -> error=1, return to IDLE; cpu_rst_n stays 0.
  - num_words=0 still requires a checksum byte of 0x00.
- Without the macro: no CHECK state; the last WRITE goes directly to DONE and there is no checksum byte.

Test Plan:
- Reset, then start with num_words=2 and bytes 13 05 00 00 93 05 10 00 -> writes 0x00000513 at address 0 and 0x00100593 at address 4. imem_we is high exactly 2 cycles; then done=1, cpu_rst_n=1.
- byte_valid toggled 1/0 every cycle during an 8-word load -> exactly 8 writes at addresses 0..28, no duplicated or dropped bytes; data at address 28 equals the last 4 bytes.
- start with num_words=65 (MEM_WORDS=64) -> error=1 next cycle, byte_ready=0, no writes; a following start with num_words=1 clears error.
- rst_n pulsed low after 6 bytes of a 2-word load -> only address 0 is written; all outputs return to reset values asynchronously; no write occurs to address 4.
- Second start pulse during COLLECT -> ignored: num_words unchanged, counter continues.
- With IMEM_LOADER_CHECKSUM_EN: 1-word image 13 05 00 00 plus checksum 0x16 -> done=1. Same image with checksum 0x17 -> error=1, state IDLE, cpu_rst_n=0.
